// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver for BCD input, with a one-clock
// blank slot between digits and optional leading-zero blanking.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] BCD_0,
    input  logic [3:0] BCD_1,
    input  logic [3:0] BCD_2,
    input  logic [3:0] BCD_3,
    input  logic       blank_lz,
    output logic [6:0] HEX_SEG,
    output logic [3:0] DIG_EN
);

    localparam int unsigned    CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = 7'b1111111;
    localparam logic [3:0]     DIG_OFF  = 4'b1111;

    logic [3:0][3:0] h;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             tick;
    logic             digit_blanked;
    logic [6:0]       seg_next;
    logic [3:0]       en_next;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);

    // A digit is a leading zero only if it and every more significant digit are zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        digit_blanked = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd3:    digit_blanked = (h[3] == 4'd0);
                2'd2:    digit_blanked = (h[3] == 4'd0) && (h[2] == 4'd0);
                2'd1:    digit_blanked = (h[3] == 4'd0) && (h[2] == 4'd0) && (h[1] == 4'd0);
                default: digit_blanked = 1'b0;
            endcase
        end
    end

    always_comb begin
        seg_next = SEG_OFF;
        en_next  = DIG_OFF;
        if (!tick && !digit_blanked) begin
            seg_next = decode(h[idx]);
            en_next  = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            h       <= '0;
            HEX_SEG <= SEG_OFF;
            DIG_EN  <= DIG_OFF;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            if (load)
                h   <= {BCD_3, BCD_2, BCD_1, BCD_0};
            HEX_SEG <= seg_next;
            DIG_EN  <= en_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display at SCAN_DIV=4: the driver queues one
// hand-computed {DIG_EN,HEX_SEG} per clock, the monitor pops and compares.
module tb_bcd_scan_display;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SD   = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [3:0] E0   = 4'b1110;
    localparam logic [3:0] E1   = 4'b1101;
    localparam logic [3:0] E2   = 4'b1011;
    localparam logic [3:0] E3   = 4'b0111;
    localparam logic [3:0] EOFF = 4'b1111;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic       blank_lz;
    logic [6:0] hex_seg;
    logic [3:0] dig_en;

    int n_tests = 0;
    int n_fail  = 0;
    int n_multi_low = 0;
    bit mon_on = 1'b0;

    logic [10:0] exp_q[$];
    string       name_q[$];
    logic [10:0] mon_exp;
    string       mon_name;

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .BCD_0    (bcd0),
        .BCD_1    (bcd1),
        .BCD_2    (bcd2),
        .BCD_3    (bcd3),
        .blank_lz (blank_lz),
        .HEX_SEG  (hex_seg),
        .DIG_EN   (dig_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got en=%b seg=%b, want en=%b seg=%b",
                     nm, $time, act[10:7], act[6:0], exp[10:7], exp[6:0]);
        end
    endtask

    // Monitor: one expected output per clock edge while the queue holds entries.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check(mon_name, {dig_en, hex_seg}, mon_exp);
        end
        if (mon_on && $countones(~dig_en) > 1)
            n_multi_low++;
    end

    // Queue the expected output for the next edge, then advance to the following negedge.
    task automatic cyc(input string nm, input logic [3:0] en, input logic [6:0] seg);
        exp_q.push_back({en, seg});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic slot(input string nm, input logic [3:0] en, input logic [6:0] seg);
        repeat (3) cyc(nm, en, seg);
        cyc({nm, "_blank"}, EOFF, SOFF);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        cyc("reset", EOFF, SOFF);
        rst  = 1'b0;
    endtask

    task automatic set_bcd(input logic [3:0] b3, input logic [3:0] b2,
                           input logic [3:0] b1, input logic [3:0] b0);
        bcd3 = b3; bcd2 = b2; bcd1 = b1; bcd0 = b0;
    endtask

    // After a reset, load the staged digits, then expect the rest of frame 1 and a full frame 2.
    // The load edge itself still shows the cleared H0 on digit 0.
    task automatic load_and_scan(input string nm,
                                 input logic [3:0] e0, input logic [6:0] s0,
                                 input logic [3:0] e1, input logic [6:0] s1,
                                 input logic [3:0] e2, input logic [6:0] s2,
                                 input logic [3:0] e3, input logic [6:0] s3);
        load = 1'b1;
        cyc({nm, "_loadedge"}, E0, S0);
        load = 1'b0;
        repeat (2) cyc({nm, "_d0"}, e0, s0);
        cyc({nm, "_d0_blank"}, EOFF, SOFF);
        slot({nm, "_d1"}, e1, s1);
        slot({nm, "_d2"}, e2, s2);
        slot({nm, "_d3"}, e3, s3);
        slot({nm, "_f2d0"}, e0, s0);
        slot({nm, "_f2d1"}, e1, s1);
        slot({nm, "_f2d2"}, e2, s2);
        slot({nm, "_f2d3"}, e3, s3);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        do_reset();
        mon_on = 1'b1;

        // 1234 with blanking off
        blank_lz = 1'b0;
        set_bcd(4'd4, 4'd3, 4'd2, 4'd1);
        load_and_scan("seq1234", E0, S1, E1, S2, E2, S3, E3, S4);

        // 0050 with leading-zero blanking
        do_reset();
        blank_lz = 1'b1;
        set_bcd(4'd0, 4'd0, 4'd5, 4'd0);
        load_and_scan("val50", E0, S0, E1, S5, EOFF, SOFF, EOFF, SOFF);

        // all zeros, blanking on: only digit 0 lit
        do_reset();
        blank_lz = 1'b1;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        load_and_scan("zeros", E0, S0, EOFF, SOFF, EOFF, SOFF, EOFF, SOFF);

        // blanking switched off: every digit shows '0' from the next slot on
        blank_lz = 1'b0;
        slot("lz_off_d0", E0, S0);
        slot("lz_off_d1", E1, S0);
        slot("lz_off_d2", E2, S0);
        slot("lz_off_d3", E3, S0);

        // invalid thousands digit: dash, and it counts as non-zero for blanking
        do_reset();
        blank_lz = 1'b1;
        set_bcd(4'd12, 4'd0, 4'd0, 4'd0);
        load_and_scan("dash", E0, S0, E1, S0, E2, S0, E3, SD);

        // reset in the middle of digit 2's slot
        do_reset();
        blank_lz = 1'b0;
        set_bcd(4'd4, 4'd3, 4'd2, 4'd1);
        load = 1'b1;
        cyc("midrst_loadedge", E0, S0);
        load = 1'b0;
        repeat (2) cyc("midrst_d0", E0, S1);
        cyc("midrst_d0_blank", EOFF, SOFF);
        slot("midrst_d1", E1, S2);
        cyc("midrst_d2", E2, S3);
        rst = 1'b1;
        cyc("midrst_reset", EOFF, SOFF);
        rst = 1'b0;
        cyc("midrst_first", E0, S0);
        repeat (2) cyc("midrst_post_d0", E0, S0);
        cyc("midrst_post_blank", EOFF, SOFF);
        slot("midrst_post_d1", E1, S0);

        // load coinciding with the tick edge that ends digit 0's slot
        do_reset();
        blank_lz = 1'b0;
        set_bcd(4'd4, 4'd3, 4'd2, 4'd1);
        load = 1'b1;
        cyc("tickload_loadedge", E0, S0);
        load = 1'b0;
        repeat (2) cyc("tickload_d0", E0, S1);
        set_bcd(4'd6, 4'd7, 4'd8, 4'd9);
        load = 1'b1;
        cyc("ticklaod_blank", EOFF, SOFF);
        load = 1'b0;
        slot("ticklaod_d1", E1, S8);
        slot("ticklaod_d2", E2, S7);
        slot("ticklaod_d3", E3, S6);
        slot("ticklaod_d0", E0, S9);

        @(negedge clk);
        check("dig_en_one_low", {7'd0, n_multi_low[3:0]}, 11'd0);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clocks per digit slot; legal range 2..2^20.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: load  input  1  capture strobe for BCD_0..BCD_3.
REQ-005 Port: BCD_0  input  4  units digit from the binary-to-BCD converter.
REQ-006 Port: BCD_1  input  4  tens digit.
REQ-007 Port: BCD_2  input  4  hundreds digit.
REQ-008 Port: BCD_3  input  4  thousands digit.
REQ-009 Port: blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-010 Port: HEX_SEG  output  7  registered segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 Port: DIG_EN  output  4  registered digit enables, active-low; bit n selects digit n.

Function
REQ-012 The block SHALL hold four 4-bit digit registers H0..H3; at an edge with load=1 and rst=0, Hn SHALL capture BCD_n; with load=0, Hn SHALL hold.
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (cnt == SCAN_DIV-1).
REQ-014 Digit index idx (2 bits) SHALL increment on every tick edge, wrapping 3->0; it SHALL hold otherwise.
REQ-015 At a tick edge, outputs SHALL be driven to DIG_EN=4'b1111, HEX_SEG=7'b1111111 (one-clock anti-ghost blank slot).
REQ-016 At a non-tick edge, outputs SHALL reflect digit idx: HEX_SEG=decode(H[idx]), DIG_EN = all ones except bit idx = 0, unless that digit is blanked (REQ-019), in which case DIG_EN=4'b1111 and HEX_SEG=7'b1111111.
REQ-017 Decode (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Digit values 10..15 SHALL decode to a dash, HEX_SEG=0111111, and SHALL count as non-zero for blanking.
REQ-019 With blank_lz=1: digit 3 blanked iff H3=0; digit 2 blanked iff H3=H2=0; digit 1 blanked iff H3=H2=H1=0; digit 0 never blanked. With blank_lz=0 no digit is blanked.
REQ-020 Latency: a value captured at edge k SHALL appear on outputs no earlier than edge k+1 (registered outputs computed from H registers, never directly from BCD_n).
REQ-021 load asserted on a tick edge SHALL still capture; the blank slot SHALL still be emitted; the next slot SHALL show new data.
REQ-022 blank_lz is sampled combinationally into the output register each non-tick edge; a change takes effect at the next non-tick edge.
REQ-023 Each digit SHALL be driven for exactly SCAN_DIV-1 consecutive clocks followed by one blank clock; full frame = 4*SCAN_DIV clocks.
REQ-024 At most one DIG_EN bit SHALL be low in any cycle.

Reset
REQ-025 At an edge with rst=1: cnt=0, idx=0, H0..H3=0, DIG_EN=4'b1111, HEX_SEG=7'b1111111; rst SHALL take priority over load and tick.
REQ-026 Reset asserted mid-slot SHALL abort the slot; the first edge after rst deasserts SHALL drive digit 0 (DIG_EN=1110, HEX_SEG=1000000 with H0=0).

Verification (SCAN_DIV=4)
REQ-027 Reset, load 1,2,3,4 (BCD_0..3), blank_lz=0 -> repeating sequence: digit0 '4'? no: DIG_EN 1110/SEG 1111001 x3, blank x1, 1101/0100100 x3, blank, 1011/0110000 x3, blank, 0111/0011001 x3, blank.
REQ-028 Load 0,5,0,0 (BCD_3..BCD_0 = 0,0,5,0 i.e. value 50), blank_lz=1 -> digits 3 and 2 emit DIG_EN=1111 for full slots; digit1 SEG 0010010; digit0 SEG 1000000.
REQ-029 Load all zeros, blank_lz=1 -> only digit 0 ever enabled, SEG 1000000; digits 1..3 dark.
REQ-030 Load BCD_3=12 (invalid), others 0, blank_lz=1 -> digit 3 shows 0111111; digits 2,1 shown as '0' (not blanked); digit 0 '0'.
REQ-031 Assert rst during digit 2 slot -> next edge outputs 1111/1111111; first post-reset edge DIG_EN=1110; H cleared (digit0 shows '0').
REQ-032 Pulse load at a tick edge with new values -> blank clock emitted, following slot shows new digit; check DIG_EN never has two low bits throughout.
